// File: rtl/input_conditioner.sv
// Board-input conditioning: two-flop synchronizers on every raw input, plus a
// consecutive-cycle debouncer and rising-edge pulse generator per button.

module input_conditioner_btn #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             w_differs;
  logic             w_qualified;
  logic             w_stable_next;

  assign w_differs     = (r_s2 != r_stable);
  assign w_qualified   = w_differs && (r_cnt == CNT_LAST);
  assign w_stable_next = w_qualified ? r_s2 : r_stable;

  // NOTE: every flop here, synchronizer stages included, is cleared by the
  // synchronous reset so a held button must requalify from scratch afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep s1->s2 a true two-stage shift.
      r_s1     <= i_btn;
      r_s2     <= r_s1;
      r_stable <= w_stable_next;
      r_pulse  <= w_stable_next & ~r_stable;
      // Any return to the stable value restarts the count; the count never
      // passes CNT_LAST because reaching it either flips the level or resets.
      if (!w_differs || w_qualified) r_cnt <= '0;
      else                           r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_level = r_stable;
  assign o_pulse = r_pulse;

endmodule

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_btn,
  input  logic        continue_btn,
  input  logic [15:0] sw_raw,
  output logic        run_o,
  output logic        run_pulse_o,
  output logic        continue_o,
  output logic        continue_pulse_o,
  output logic [15:0] sw_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [15:0] r_sw_s1;
  logic [15:0] r_sw_s2;

  input_conditioner_btn #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_run (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (run_btn),
    .o_level (run_o),
    .o_pulse (run_pulse_o)
  );

  input_conditioner_btn #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_continue (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (continue_btn),
    .o_level (continue_o),
    .o_pulse (continue_pulse_o)
  );

  // Switches are level inputs: synchronize only, no debounce or edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw_raw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  assign sw_o = r_sw_s2;

endmodule
